// File: rtl/wtm_accum.sv
// Accumulates NUM_TERMS {cout,out} products from the wtm multiplier and presents
// the wrapped sum plus a sticky overflow flag on a valid/ready output handshake.
module wtm_accum #(
  parameter  int NUM_TERMS = 4,
  parameter  int ACC_W     = 12,
  localparam int CNT_W     = $clog2(NUM_TERMS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_prod,
  input  logic             in_cout,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] term_cnt
);

  localparam int TERM_W = 11;
  // Wide enough that every bit the add pushes past ACC_W is visible to the carry test.
  localparam int SUM_W = ((ACC_W > TERM_W) ? ACC_W : TERM_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [SUM_W-1:0] term_ext;
  logic [SUM_W-1:0] sum_full;
  logic             carry;
  logic             accept;
  logic             last_beat;

  assign term_ext  = SUM_W'({in_cout, in_prod});
  assign sum_full  = SUM_W'(acc_q) + term_ext;
  assign carry     = |sum_full[SUM_W-1:ACC_W];
  assign accept    = in_valid && in_ready && !clear;
  assign last_beat = accept && (cnt_q == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACCUM;
    end else begin
      unique case (state_q)
        ACCUM: if (last_beat) state_d = HOLD;
        HOLD:  if (out_ready) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_q == ACCUM);
  end

  // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    if (clear) begin
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d = sum_full[ACC_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (carry) ovf_d = 1'b1;
            if (last_beat) begin
              sum_d   = sum_full[ACC_W-1:0];
              valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_ovf   = ovf_q;
  assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_wtm_accum.sv
// Self-checking bench for wtm_accum: table of four-beat groups, scoreboard on the
// output handshake, and directed backpressure, clear, reset and gap sequences.
module tb_wtm_accum;

  localparam int NUM_TERMS = 4;
  localparam int ACC_W     = 12;
  localparam int CNT_W     = $clog2(NUM_TERMS + 1);

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [9:0]       in_prod;
  logic             in_cout;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] term_cnt;

  wtm_accum #(.NUM_TERMS(NUM_TERMS), .ACC_W(ACC_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .in_cout  (in_cout),
    .clear    (clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .term_cnt (term_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [10:0]      t [4];
    logic [ACC_W-1:0] exp_sum;
    logic             exp_ovf;
  } vec_t;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a result is compared at the negedge before the edge that consumes it.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        check("sb_out_sum", out_sum, r.sum);
        check("sb_out_ovf", out_ovf, r.ovf);
      end
    end
  end

  // Called and returns at posedge+1; offers one beat until it is accepted.
  task automatic send(input logic [10:0] t);
    int n;
    in_valid = 1'b1;
    {in_cout, in_prod} = t;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("beat_accept_timeout", in_ready, 1'b1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_group(input vec_t v, input int max_gap);
    res_t r;
    r.sum = v.exp_sum;
    r.ovf = v.exp_ovf;
    exp_q.push_back(r);
    for (int j = 0; j < 4; j++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        @(posedge clock);
        #1;
      end
      send(v.t[j]);
      @(negedge clock);
      if (j < 3) begin
        check("term_cnt_progress", term_cnt, j + 1);
        check("no_early_valid", out_valid, 1'b0);
      end else begin
        check("valid_latency", out_valid, 1'b1);
        check("hold_in_ready", in_ready, 1'b0);
        check("hold_term_cnt", term_cnt, NUM_TERMS);
        check("result_sum", out_sum, v.exp_sum);
        check("result_ovf", out_ovf, v.exp_ovf);
      end
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    check("post_hs_valid", out_valid, 1'b0);
    check("post_hs_term_cnt", term_cnt, 0);
    check("post_hs_ovf", out_ovf, 1'b0);
    check("post_hs_sum_kept", out_sum, v.exp_sum);
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t v;
    res_t r;
    vecs[0] = '{'{11'd0, 11'd400, 11'd31, 11'd961}, 12'd1392, 1'b0};
    vecs[1] = '{'{11'd2047, 11'd2047, 11'd2047, 11'd2047}, 12'd4092, 1'b1};
    vecs[2] = '{'{11'd1, 11'd1, 11'd1, 11'd1}, 12'd4, 1'b0};
    vecs[3] = '{'{11'd1000, 11'd1000, 11'd1000, 11'd1095}, 12'd4095, 1'b0};
    vecs[4] = '{'{11'd1024, 11'd1024, 11'd1024, 11'd1024}, 12'd0, 1'b1};
    vecs[5] = '{'{11'd2047, 11'd2047, 11'd2047, 11'd0}, 12'd2045, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_cout   = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_term_cnt", term_cnt, 0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_group(vecs[i], 0);

    // Backpressure: result held while a new beat waits, then that beat is term 1.
    out_ready = 1'b0;
    r.sum = 12'd1392;
    r.ovf = 1'b0;
    exp_q.push_back(r);
    for (int j = 0; j < 4; j++) send(vecs[0].t[j]);
    in_valid = 1'b1;
    {in_cout, in_prod} = 11'd5;
    repeat (3) begin
      @(negedge clock);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_sum", out_sum, 12'd1392);
      check("bp_term_cnt", term_cnt, NUM_TERMS);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_hs_in_ready", in_ready, 1'b0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("bp_after_hs_ready", in_ready, 1'b1);
    check("bp_after_hs_cnt", term_cnt, 0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("bp_next_beat_term1", term_cnt, 1);
    r.sum = 12'd8;
    r.ovf = 1'b0;
    exp_q.push_back(r);
    @(posedge clock);
    #1;
    for (int j = 0; j < 3; j++) send(11'd1);
    @(negedge clock);
    check("bp_tail_valid", out_valid, 1'b1);
    check("bp_tail_sum", out_sum, 12'd8);
    @(posedge clock);
    #1;

    // Clear together with the second beat drops the beat and the partial sum.
    send(11'd31);
    in_valid = 1'b1;
    {in_cout, in_prod} = 11'd400;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("clr_term_cnt", term_cnt, 0);
    @(posedge clock);
    #1;
    run_group(vecs[2], 0);

    // Clear in HOLD discards the pending result but leaves out_sum.
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) send(vecs[1].t[j]);
    @(negedge clock);
    check("clrh_valid_before", out_valid, 1'b1);
    check("clrh_ovf_before", out_ovf, 1'b1);
    @(posedge clock);
    #1;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
    check("clrh_valid", out_valid, 1'b0);
    check("clrh_ovf", out_ovf, 1'b0);
    check("clrh_term_cnt", term_cnt, 0);
    check("clrh_in_ready", in_ready, 1'b1);
    check("clrh_sum_kept", out_sum, 12'd4092);
    @(posedge clock);
    #1;
    out_ready = 1'b1;

    // Asynchronous reset in the middle of an accumulation.
    for (int j = 0; j < 3; j++) send(11'd2047);
    #3;
    check("pre_rst_ovf", out_ovf, 1'b1);
    reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_sum", out_sum, 0);
    check("arst_out_ovf", out_ovf, 1'b0);
    check("arst_term_cnt", term_cnt, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("arst_in_ready", in_ready, 1'b1);
    @(posedge clock);
    #1;
    run_group(vecs[0], 0);

    // Random idle cycles between beats give the same result.
    v = vecs[0];
    run_group(v, 3);
    run_group(vecs[1], 2);

    check("sb_leftover", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
